// File: rtl/gray_counter_n_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gray_counter_n_pkg
// Purpose : Shared constants for the Gray counter / converter block:
//           bound behaviour, converter mode encodings and the default width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gray_counter_n_pkg;

  // Default counter / converter width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // Bound behaviour selected by the WRAP parameter.
  localparam int WRAP_SAT = 0;  // hold at the bound
  localparam int WRAP_EN  = 1;  // roll over modulo 2^WIDTH

  // Converter mode encodings carried on cv_mode.
  localparam logic CV_B2G = 1'b0;  // binary -> Gray
  localparam logic CV_G2B = 1'b1;  // Gray -> binary

endpackage : gray_counter_n_pkg
`default_nettype wire

// File: rtl/gray_counter_n_gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module  : gray_to_bin
// Purpose : Combinational Gray-to-binary converter. Each binary bit is the
//           XOR of all Gray bits at and above its position.
// Ports   : gray_in  - Gray-coded operand (WIDTH bits)
//           bin_out  - binary result (WIDTH bits)
// Revision: 1.0 - initial release
// ============================================================================
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  // The MSB passes straight through; every lower bit folds in the
  // already-decoded bit above it, forming a prefix XOR from the top down.
  assign bin_out[WIDTH-1] = gray_in[WIDTH-1];

  genvar i;
  generate
    for (i = WIDTH - 2; i >= 0; i--) begin : g_bit
      assign bin_out[i] = bin_out[i+1] ^ gray_in[i];
    end
  endgenerate

endmodule : gray_to_bin
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module  : gray_counter_n
// Purpose : Up/down binary counter with registered Gray-code output, load,
//           wrap-or-saturate bound handling and a terminal-count flag, plus
//           an independent one-cycle binary<->Gray converter.
// Ports   : clk          - clock, rising edge
//           rst          - synchronous active-high reset
//           en           - count enable
//           up           - direction, 1 = increment, 0 = decrement
//           load         - synchronous load strobe (beats en)
//           load_bin     - binary load value
//           bin          - registered binary count
//           gray         - registered Gray code of the count
//           tc           - registered terminal-count flag
//           cv_valid_in  - converter operand valid
//           cv_mode      - 0 = binary->Gray, 1 = Gray->binary
//           cv_in        - converter operand
//           cv_valid_out - converter result valid (cv_valid_in delayed 1)
//           cv_out       - converter result, held while no new operand
// Revision: 1.0 - initial release
// ============================================================================
module gray_counter_n
  import gray_counter_n_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WRAP  = WRAP_EN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  input  logic             cv_valid_in,
  input  logic             cv_mode,
  input  logic [WIDTH-1:0] cv_in,
  output logic             cv_valid_out,
  output logic [WIDTH-1:0] cv_out
);

  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_COUNT = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               DO_WRAP   = (WRAP != WRAP_SAT);

  // --------------------------------------------------------------------------
  // Counter
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] bin_d,  bin_q;
  logic [WIDTH-1:0] gray_d, gray_q;
  logic             tc_d,   tc_q;
  logic             at_bound;

  always_comb begin
    bin_d    = bin_q;
    tc_d     = 1'b0;
    at_bound = up ? (bin_q == MAX_COUNT) : (bin_q == MIN_COUNT);

    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (at_bound) begin
        // Stepping past the bound either rolls over or is refused; both
        // cases raise tc for the following cycle.
        tc_d = 1'b1;
        if (DO_WRAP) begin
          bin_d = up ? MIN_COUNT : MAX_COUNT;
        end
      end else begin
        bin_d = up ? (bin_q + ONE) : (bin_q - ONE);
      end
    end

    // Gray is derived from the next binary value so both registers always
    // describe the same count.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = tc_q;

  // --------------------------------------------------------------------------
  // Converter
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] cv_g2b;
  logic [WIDTH-1:0] cv_result;
  logic [WIDTH-1:0] cv_out_d,       cv_out_q;
  logic             cv_valid_out_d, cv_valid_out_q;

  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_gray_to_bin (
    .gray_in (cv_in),
    .bin_out (cv_g2b)
  );

  always_comb begin
    cv_result      = (cv_mode == CV_G2B) ? cv_g2b : (cv_in ^ (cv_in >> 1));
    cv_valid_out_d = cv_valid_in;
    cv_out_d       = cv_valid_in ? cv_result : cv_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_valid_out_q <= 1'b0;
      cv_out_q       <= '0;
    end else begin
      cv_valid_out_q <= cv_valid_out_d;
      cv_out_q       <= cv_out_d;
    end
  end

  assign cv_valid_out = cv_valid_out_q;
  assign cv_out       = cv_out_q;

endmodule : gray_counter_n
`default_nettype wire

// File: tb/tb_gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_gray_counter_n
// Purpose : Self-checking bench for gray_counter_n. Two instances share one
//           stimulus stream: index 0 wraps at the bounds, index 1 saturates.
//           Outputs are compared every cycle against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gray_counter_n;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, up, load, cv_valid_in, cv_mode;
  logic [W-1:0] load_bin, cv_in;

  logic [W-1:0] bin_o  [2];
  logic [W-1:0] gray_o [2];
  logic         tc_o   [2];
  logic         cvv_o  [2];
  logic [W-1:0] cvo_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_bin [2];
  int m_tc  [2];
  int m_cvv;
  int m_cvo;
  logic [W-1:0] prev_gray;
  bit           counted;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(W), .WRAP(1)) u_dut_wrap (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .load_bin (load_bin), .bin (bin_o[0]), .gray (gray_o[0]), .tc (tc_o[0]),
    .cv_valid_in (cv_valid_in), .cv_mode (cv_mode), .cv_in (cv_in),
    .cv_valid_out (cvv_o[0]), .cv_out (cvo_o[0])
  );

  gray_counter_n #(.WIDTH(W), .WRAP(0)) u_dut_sat (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .load_bin (load_bin), .bin (bin_o[1]), .gray (gray_o[1]), .tc (tc_o[1]),
    .cv_valid_in (cv_valid_in), .cv_mode (cv_mode), .cv_in (cv_in),
    .cv_valid_out (cvv_o[1]), .cv_out (cvo_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int n);
    return n ^ (n >> 1);
  endfunction

  // Gray -> binary: bit i is the parity of the Gray bits from i upward.
  function automatic int from_gray(input int g);
    int r = 0;
    for (int i = 0; i < W; i++) begin
      if ($countones(g >> i) % 2 == 1) r |= (1 << i);
    end
    return r;
  endfunction

  // Advance the model using the inputs present at this edge.
  task automatic model_edge();
    int nxt;
    counted = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_bin[k] = 0; m_tc[k] = 0;
      end else if (load) begin
        m_bin[k] = int'(load_bin); m_tc[k] = 0;
      end else if (en) begin
        nxt = m_bin[k] + (up ? 1 : -1);
        if (nxt < 0 || nxt >= M) begin
          m_tc[k]  = 1;
          m_bin[k] = (k == 0) ? ((nxt + M) % M) : m_bin[k];
        end else begin
          m_tc[k]  = 0;
          m_bin[k] = nxt;
        end
        if (k == 0) counted = 1'b1;
      end else begin
        m_tc[k] = 0;
      end
    end
    if (rst) begin
      m_cvv = 0; m_cvo = 0;
    end else begin
      m_cvv = int'(cv_valid_in);
      if (cv_valid_in)
        m_cvo = cv_mode ? from_gray(int'(cv_in)) : to_gray(int'(cv_in));
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bin[%0d]", k),  32'(bin_o[k]),  32'(m_bin[k]));
      check($sformatf("gray[%0d]", k), 32'(gray_o[k]), 32'(to_gray(m_bin[k])));
      check($sformatf("tc[%0d]", k),   32'(tc_o[k]),   32'(m_tc[k]));
      check($sformatf("cv_valid_out[%0d]", k), 32'(cvv_o[k]), 32'(m_cvv));
      check($sformatf("cv_out[%0d]", k),       32'(cvo_o[k]), 32'(m_cvo));
    end
    if (counted) check("gray_one_bit_step", 32'($countones(gray_o[0] ^ prev_gray)), 32'd1);
  endtask

  task automatic tick();
    prev_gray = gray_o[0];
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
    cv_valid_in = 1'b0; cv_mode = 1'b0; cv_in = '0;
    m_bin = '{0, 0}; m_tc = '{0, 0}; m_cvv = 0; m_cvo = 0;
    prev_gray = '0; counted = 1'b0;

    // Reset state
    tick();
    check("reset_bin", 32'(bin_o[0]), 32'd0);

    // Up count through a full wrap
    rst = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("first_gray", 32'(gray_o[0]), 32'b0001);
    for (int i = 0; i < 14; i++) tick();
    check("max_gray", 32'(gray_o[0]), 32'b1000);
    tick();
    check("wrap_gray", 32'(gray_o[0]), 32'd0);
    check("wrap_tc", 32'(tc_o[0]), 32'd1);
    tick();
    check("tc_one_cycle", 32'(tc_o[0]), 32'd0);

    // Load beats enable
    load = 1'b1; load_bin = 4'd9; en = 1'b1;
    tick();
    check("load_bin", 32'(bin_o[0]), 32'b1001);
    check("load_gray", 32'(gray_o[0]), 32'b1101);
    check("load_tc", 32'(tc_o[1]), 32'd0);

    // Down wrap from 0
    load_bin = 4'd0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("down_wrap_bin", 32'(bin_o[0]), 32'd15);
    check("down_wrap_gray", 32'(gray_o[0]), 32'b1000);
    check("down_wrap_tc", 32'(tc_o[0]), 32'd1);
    check("down_sat_bin", 32'(bin_o[1]), 32'd0);

    // Saturation at the top
    load = 1'b1; load_bin = 4'd15;
    tick();
    load = 1'b0; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold_bin", 32'(bin_o[1]), 32'd15);
      check("sat_hold_tc", 32'(tc_o[1]), 32'd1);
    end
    up = 1'b0;
    tick();
    check("sat_release_bin", 32'(bin_o[1]), 32'd14);
    check("sat_release_tc", 32'(tc_o[1]), 32'd0);

    // Converter vectors
    en = 1'b0;
    cv_valid_in = 1'b1; cv_mode = 1'b0; cv_in = 4'b1010;
    tick();
    check("cv_b2g", 32'(cvo_o[0]), 32'b1111);
    check("cv_b2g_valid", 32'(cvv_o[0]), 32'd1);
    cv_mode = 1'b1; cv_in = 4'b1101;
    tick();
    check("cv_g2b", 32'(cvo_o[0]), 32'b1001);
    cv_valid_in = 1'b0; cv_in = 4'b0110;
    tick();
    check("cv_hold", 32'(cvo_o[0]), 32'b1001);
    check("cv_valid_drop", 32'(cvv_o[0]), 32'd0);

    // Reset mid-count and mid-conversion
    load = 1'b1; load_bin = 4'd7;
    tick();
    load = 1'b0; rst = 1'b1; en = 1'b1; up = 1'b1; cv_valid_in = 1'b1;
    tick();
    check("rst_bin", 32'(bin_o[0]), 32'd0);
    check("rst_cv_valid", 32'(cvv_o[0]), 32'd0);
    check("rst_cv_out", 32'(cvo_o[0]), 32'd0);
    rst = 1'b0; cv_valid_in = 1'b0;
    tick();
    check("resume_bin", 32'(bin_o[0]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      load        = ($urandom_range(0, 9) == 0);
      load_bin    = W'($urandom);
      en          = ($urandom_range(0, 3) != 0);
      up          = (i % 128 < 64) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      cv_valid_in = $urandom_range(0, 1) == 1;
      cv_mode     = $urandom_range(0, 1) == 1;
      cv_in       = W'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gray_counter_n
`default_nettype wire

// File: doc/gray_counter_n.md
GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the counter and converter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter WRAP, default 1, meaning 1 = wrap at bounds and 0 = saturate at bounds.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, the count enable.
REQ-006 The block SHALL have port up, input, 1 bit, the count direction: 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit, the synchronous load strobe.
REQ-008 The block SHALL have port load_bin, input, WIDTH bits, the binary load value.
REQ-009 The block SHALL have port bin, output, WIDTH bits, the registered binary count.
REQ-010 The block SHALL have port gray, output, WIDTH bits, the registered Gray code of the count.
REQ-011 The block SHALL have port tc, output, 1 bit, the registered terminal-count flag.
REQ-012 The block SHALL have port cv_valid_in, input, 1 bit, the converter input valid.
REQ-013 The block SHALL have port cv_mode, input, 1 bit, the converter mode: 0 = binary to Gray, 1 = Gray to binary.
REQ-014 The block SHALL have port cv_in, input, WIDTH bits, the converter operand.
REQ-015 The block SHALL have port cv_valid_out, output, 1 bit, the converter result valid.
REQ-016 The block SHALL have port cv_out, output, WIDTH bits, the converter result.

Function
REQ-017 Counter priority per edge SHALL be: rst, then load, then en, otherwise hold.
REQ-018 On load, bin SHALL take load_bin and gray SHALL take load_bin ^ (load_bin >> 1) at the same edge, and tc SHALL be 0.
REQ-019 With en=1 and up=1, bin SHALL increment by 1 modulo 2^WIDTH when WRAP=1; when WRAP=0 it SHALL hold at 2^WIDTH-1.
REQ-020 With en=1 and up=0, bin SHALL decrement by 1 modulo 2^WIDTH when WRAP=1; when WRAP=0 it SHALL hold at 0.
REQ-021 gray SHALL always equal bin ^ (bin >> 1); both SHALL be registered and update on the same edge, with one-cycle latency from en/load.
REQ-022 When WRAP=1, tc SHALL be 1 for exactly the one cycle following an edge on which the count wrapped (max to 0 going up, 0 to max going down).
REQ-023 When WRAP=0, tc SHALL be 1 for every cycle following an edge on which en=1 and the count was held at the bound in the current direction.
REQ-024 Between successive enabled counts, gray SHALL change in exactly one bit, including across a wrap.
REQ-025 The converter SHALL be independent of the counter, have one-cycle latency and apply no backpressure: cv_valid_out equals cv_valid_in delayed by one cycle.
REQ-026 In mode 0, cv_out SHALL be cv_in ^ (cv_in >> 1); in mode 1, cv_out[i] SHALL be the XOR of cv_in[WIDTH-1:i].
REQ-027 cv_out SHALL update only when cv_valid_in=1 and SHALL hold its last value otherwise.
REQ-028 Simultaneous load and en SHALL apply the load only; en during rst SHALL be ignored.

Reset
REQ-029 A reset SHALL be synchronous, active-high, and override every other input on the same edge.
REQ-030 On reset, bin, gray, tc, cv_valid_out and cv_out SHALL all be 0.
REQ-031 A reset asserted mid-count or mid-conversion SHALL discard all state; the first count after release SHALL start from 0.

Structure
REQ-032 A shared package SHALL hold the WRAP mode constants, the cv_mode encodings (CV_B2G=0, CV_G2B=1) and the default WIDTH.
REQ-033 Gray-to-binary prefix-XOR logic SHALL be a combinational sub-module gray_to_bin, parameterised by WIDTH and instantiated by the converter path.

Verification
REQ-034 With WIDTH=4 and WRAP=1, up count from reset: gray SHALL step 0000, 0001, 0011, 0010 … 1000 (bin 15), then 0000 with tc=1 for one cycle.
REQ-035 With WIDTH=4, load_bin=9 together with en=1: the next cycle SHALL show bin=1001, gray=1101, tc=0.
REQ-036 With WIDTH=4 and WRAP=1, en=1 and up=0 at bin=0: the next cycle SHALL show bin=1111, gray=1000, tc=1.
REQ-037 With WIDTH=4 and WRAP=0, up count at bin=15 for 3 cycles: bin SHALL stay 15 and tc SHALL stay 1; after switching to up=0, bin SHALL be 14 and tc=0.
REQ-038 On the converter, mode 0 with cv_in=1010 SHALL give cv_out=1111, and mode 1 with cv_in=1101 SHALL give cv_out=1001, each one cycle later with cv_valid_out=1.
REQ-039 With rst asserted for one cycle at bin=7 and cv_valid_in=1: the next cycle SHALL show all outputs 0, and counting SHALL resume from 0.
